// File: rtl/registry_pkg.sv
// Shared definitions for the registry write path and its readback serialiser.
// Both sides use pack_word so the {address, value} word layout cannot drift apart.
package registry_pkg;

    localparam int C_UART_DATA_WIDTH_DEF = 8;
    localparam int C_REG_WIDTH_DEF       = 5;

    function automatic int reg_count_width(input int uart_w, input int reg_w);
        return uart_w - reg_w;
    endfunction

    function automatic int reg_count(input int uart_w, input int reg_w);
        return 1 << reg_count_width(uart_w, reg_w);
    endfunction

    function automatic int reg_port_width(input int uart_w, input int reg_w);
        return reg_count(uart_w, reg_w) * reg_w;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        RELEASE
    } state_t;

    // Callers pass zero-extended fields and truncate the result to the UART width.
    function automatic logic [31:0] pack_word(input logic [31:0] addr,
                                              input logic [31:0] value,
                                              input int          reg_w);
        return (addr << reg_w) | value;
    endfunction

endpackage

// File: rtl/registry_dump.sv
// Serialises a snapshot of the register bank as {address, value} words over a four-phase
// valid/ack handshake. Define REGISTRY_DUMP_ONCHANGE_EN to add automatic dumps of changed registers.
module registry_dump
    import registry_pkg::*;
#(
    parameter  int C_UART_DATA_WIDTH = C_UART_DATA_WIDTH_DEF,
    parameter  int C_REG_WIDTH       = C_REG_WIDTH_DEF,
    localparam int C_REG_COUNT_WIDTH = reg_count_width(C_UART_DATA_WIDTH, C_REG_WIDTH),
    localparam int C_REG_COUNT       = reg_count(C_UART_DATA_WIDTH, C_REG_WIDTH),
    localparam int C_REG_PORT_WIDTH  = reg_port_width(C_UART_DATA_WIDTH, C_REG_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic [C_REG_PORT_WIDTH-1:0]  register,
    input  logic                         dump,
    output logic [C_UART_DATA_WIDTH-1:0] data,
    output logic                         valid,
    input  logic                         ack,
    output logic                         busy,
    output logic                         done
);

    localparam logic [C_REG_COUNT_WIDTH-1:0] LAST_ADDR = C_REG_COUNT_WIDTH'(C_REG_COUNT - 1);

    state_t                         state_q;
    logic [C_REG_COUNT_WIDTH-1:0]   addr_q;
    logic [C_REG_WIDTH-1:0]         snap_q [C_REG_COUNT];
    logic [C_UART_DATA_WIDTH-1:0]   data_q;
    logic                           valid_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           pend_q;
    logic                           start_auto;
    logic                           skip;

`ifdef REGISTRY_DUMP_ONCHANGE_EN
    logic [C_REG_WIDTH-1:0]         last_q [C_REG_COUNT];
    logic                           auto_q;

    always_comb begin
        start_auto = 1'b0;
        for (int i = 0; i < C_REG_COUNT; i++) begin
            if (register[i*C_REG_WIDTH +: C_REG_WIDTH] != last_q[i]) begin
                start_auto = 1'b1;
            end
        end
    end

    // Automatic dumps only send registers that differ from what the host last saw.
    assign skip = auto_q && (snap_q[addr_q] == last_q[addr_q]);
`else
    assign start_auto = 1'b0;
    assign skip       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= 1'b0;
`ifdef REGISTRY_DUMP_ONCHANGE_EN
            auto_q  <= 1'b0;
            for (int i = 0; i < C_REG_COUNT; i++) begin
                last_q[i] <= '0;
            end
`endif
        end else begin
            done_q <= 1'b0;
            if (busy_q && dump) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (dump || pend_q || start_auto) begin
                        for (int i = 0; i < C_REG_COUNT; i++) begin
                            snap_q[i] <= register[i*C_REG_WIDTH +: C_REG_WIDTH];
                        end
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        pend_q  <= 1'b0;
                        state_q <= LOAD;
`ifdef REGISTRY_DUMP_ONCHANGE_EN
                        auto_q  <= !(dump || pend_q);
`endif
                    end
                end
                LOAD: begin
                    if (skip) begin
                        if (addr_q == LAST_ADDR) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end else begin
                        data_q  <= C_UART_DATA_WIDTH'(pack_word(32'(addr_q), 32'(snap_q[addr_q]),
                                                               C_REG_WIDTH));
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    // valid rises one edge after data so the word is stable a cycle early.
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (ack) begin
                        valid_q <= 1'b0;
                        state_q <= RELEASE;
`ifdef REGISTRY_DUMP_ONCHANGE_EN
                        last_q[addr_q] <= snap_q[addr_q];
`endif
                    end
                end
                RELEASE: begin
                    if (!ack) begin
                        if (addr_q == LAST_ADDR) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            addr_q  <= addr_q + 1'b1;
                            state_q <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_registry_dump.sv
// Directed bench for registry_dump: a word-queue model fed from the dump input, an ack responder,
// and literal expectations for the reference register image.
module tb_registry_dump;

    localparam int UW = 8;
    localparam int RW = 5;
    localparam int N  = 8;

    logic            clk = 1'b0;
    logic            rstb = 1'b0;
    logic            dump = 1'b0;
    logic            ack = 1'b0;
    logic [N*RW-1:0] register = '0;
    logic [UW-1:0]   data;
    logic            valid;
    logic            busy;
    logic            done;

    always #5 clk = ~clk;

    registry_dump #(.C_UART_DATA_WIDTH(UW), .C_REG_WIDTH(RW)) dut (
        .clk(clk), .rstb(rstb), .register(register), .dump(dump),
        .data(data), .valid(valid), .ack(ack), .busy(busy), .done(done)
    );

    int            checks = 0;
    int            failures = 0;
    logic [UW-1:0] exp_q [$];
    logic [UW-1:0] log_q [$];
    int            done_cnt = 0;
    int            hs_cnt = 0;
    int            cur_len = 0;
    bit            busy_m = 1'b0;
    bit            pend_m = 1'b0;
    bit            prev_ok = 1'b0;
    logic [UW-1:0] prev_data = '0;
    logic [UW-1:0] hold_data = '0;
    int            hold_cycles = 0;
`ifdef REGISTRY_DUMP_ONCHANGE_EN
    logic [RW-1:0] last_m [N];
`endif

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    function automatic int reg_of(input int i);
        return int'(register[i*RW +: RW]);
    endfunction

    // Expected words for one dump: word = address * 2^RW + value, from the bank as it is now.
    function automatic void start_dump(input bit only_changed);
        int cnt = 0;
        for (int i = 0; i < N; i++) begin
`ifdef REGISTRY_DUMP_ONCHANGE_EN
            if (only_changed && reg_of(i) == int'(last_m[i])) continue;
`endif
            exp_q.push_back(UW'(i * (1 << RW) + reg_of(i)));
            cnt++;
        end
        if (only_changed && cnt == 0) return;
        cur_len = cnt;
        busy_m  = 1'b1;
    endfunction

`ifdef REGISTRY_DUMP_ONCHANGE_EN
    function automatic bit changed_m();
        for (int i = 0; i < N; i++) if (reg_of(i) != int'(last_m[i])) return 1'b1;
        return 1'b0;
    endfunction
`endif

    // Compare process: all model state is owned here.
    always @(negedge clk) begin
        if (!rstb) begin
            exp_q.delete();
            busy_m = 1'b0;
            pend_m = 1'b0;
            hs_cnt = 0;
            prev_ok = 1'b0;
`ifdef REGISTRY_DUMP_ONCHANGE_EN
            for (int i = 0; i < N; i++) last_m[i] = '0;
`endif
        end else begin
            if (valid) begin
                chk("busy_with_valid", int'(busy), 1);
                if (prev_ok) chk("data_stable", int'(data), int'(prev_data));
            end
            if (valid && ack) begin
                chk("word_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("word", int'(data), int'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
`ifdef REGISTRY_DUMP_ONCHANGE_EN
                last_m[data[UW-1:RW]] = data[RW-1:0];
`endif
                log_q.push_back(data);
                hs_cnt++;
            end
            if (done) begin
                chk("done_while_busy", int'(busy_m), 1);
                chk("done_word_count", hs_cnt, cur_len);
                done_cnt++;
                hs_cnt = 0;
                busy_m = 1'b0;
                if (pend_m) begin
                    pend_m = 1'b0;
                    start_dump(1'b0);
                end
            end
            if (dump) begin
                if (!busy_m) start_dump(1'b0);
                else pend_m = 1'b1;
            end
`ifdef REGISTRY_DUMP_ONCHANGE_EN
            else if (!busy_m && changed_m()) start_dump(1'b1);
`endif
            prev_data = data;
            prev_ok   = 1'b1;
        end
    end

    // Transmitter: acks after an optional hold on one word value, then waits for valid to drop.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rstb) begin
                ack = 1'b0;
                wcnt = 0;
            end else if (ack) begin
                if (!valid) ack = 1'b0;
            end else if (valid) begin
                if (hold_cycles > 0 && data == hold_data && wcnt < hold_cycles) begin
                    wcnt++;
                end else begin
                    ack = 1'b1;
                    wcnt = 0;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_reg(input int i, input logic [RW-1:0] v);
        register[i*RW +: RW] = v;
    endtask

    task automatic pulse_dump();
        dump = 1'b1;
        cyc(1);
        dump = 1'b0;
    endtask

    task automatic wait_done(input int target, input int max_cyc);
        int n = 0;
        while (done_cnt < target && n < max_cyc) begin
            cyc(1);
            n++;
        end
        chk("done_reached", int'(done_cnt >= target), 1);
    endtask

    task automatic wait_word(input logic [UW-1:0] w, input int max_cyc);
        int n = 0;
        while (!(valid && data == w) && n < max_cyc) begin
            cyc(1);
            n++;
        end
        chk("word_reached", int'(valid && data == w), 1);
    endtask

    task automatic wait_quiet(input int max_cyc);
        int n = 0;
        int q = 0;
        while (q < 10 && n < max_cyc) begin
            cyc(1);
            n++;
            q = busy ? 0 : q + 1;
        end
        chk("quiet_reached", int'(q >= 10), 1);
    endtask

    initial begin
        logic [UW-1:0] t1 [8];
        int base;
        int d0;
        t1 = '{8'h1F, 8'h20, 8'h40, 8'h6A, 8'h80, 8'hA0, 8'hC0, 8'hE0};

        // Reset state
        cyc(3);
        chk("rst_data", int'(data), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rstb = 1'b1;
        cyc(1);

        // Reference image, latency and word order
        base = log_q.size();
        d0 = done_cnt;
        set_reg(0, 5'h1F);
        set_reg(3, 5'h0A);
        set_reg(7, 5'h00);
        pulse_dump();
        chk("lat_edge_n_valid", int'(valid), 0);
        chk("lat_edge_n_busy", int'(busy), 1);
        cyc(1);
        chk("lat_edge_n1_valid", int'(valid), 0);
        cyc(1);
        chk("lat_edge_n2_valid", int'(valid), 1);
        wait_done(d0 + 1, 500);
        cyc(5);
        chk("t1_count", log_q.size() - base, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t1_word%0d", i), int'(log_q[base+i]), int'(t1[i]));
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_busy_after", int'(busy), 0);

        // Snapshot isolation
        base = log_q.size();
        d0 = done_cnt;
        pulse_dump();
        set_reg(2, 5'h15);
        wait_done(d0 + 1, 500);
        chk("snap_word2", int'(log_q[base+2]), 8'h40);
`ifdef REGISTRY_DUMP_ONCHANGE_EN
        wait_quiet(500);
`endif

        // Long ack stall on word 4
        hold_data = 8'h80;
        hold_cycles = 50;
        base = log_q.size();
        d0 = done_cnt;
        pulse_dump();
        wait_word(8'h80, 200);
        for (int i = 0; i < 45; i++) begin
            cyc(1);
            chk("stall_valid", int'(valid), 1);
            chk("stall_data", int'(data), 8'h80);
        end
        wait_done(d0 + 1, 500);
        hold_cycles = 0;
        chk("stall_count", log_q.size() - base, 8);
        chk("stall_word4", int'(log_q[base+4]), 8'h80);
        chk("stall_word5", int'(log_q[base+5]), 8'hA0);
`ifdef REGISTRY_DUMP_ONCHANGE_EN
        wait_quiet(500);
`endif

        // Repeated requests collapse into one pending dump
        base = log_q.size();
        d0 = done_cnt;
        pulse_dump();
        cyc(6);
        pulse_dump();
        cyc(5);
        pulse_dump();
        cyc(7);
        pulse_dump();
        wait_done(d0 + 2, 1000);
        cyc(20);
        chk("pend_count", log_q.size() - base, 16);
        chk("pend_second_first", int'(log_q[base+8]), 8'h1F);
        chk("pend_done_twice", done_cnt - d0, 2);
        chk("pend_busy_after", int'(busy), 0);

        // Reset during word 5
        hold_data = 8'hA0;
        hold_cycles = 10;
        base = log_q.size();
        pulse_dump();
        wait_word(8'hA0, 200);
        rstb = 1'b0;
        cyc(1);
        chk("abort_valid", int'(valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_data", int'(data), 0);
        chk("abort_count", log_q.size() - base, 5);
        rstb = 1'b1;
        hold_cycles = 0;
        cyc(30);
`ifndef REGISTRY_DUMP_ONCHANGE_EN
        chk("abort_no_more", log_q.size() - base, 5);
        chk("abort_idle_valid", int'(valid), 0);
        base = log_q.size();
        d0 = done_cnt;
        pulse_dump();
        wait_done(d0 + 1, 500);
        chk("recover_count", log_q.size() - base, 8);
`else
        wait_quiet(500);
        pulse_dump();
        wait_quiet(500);
        base = log_q.size();
        d0 = done_cnt;
        set_reg(6, 5'h03);
        wait_done(d0 + 1, 500);
        cyc(20);
        chk("auto_count", log_q.size() - base, 1);
        chk("auto_word", int'(log_q[base]), 8'hC3);
        chk("auto_done_once", done_cnt - d0, 1);
`endif

        chk("model_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
